// File: rtl/dcm_clkgen_prog.sv
// rtl/dcm_clkgen_prog.sv - DCM_CLKGEN PROGEN/PROGDATA serial loader for M/D reprogramming.
// Optional WAIT_DONE timeout enabled by defining DCM_PROG_TIMEOUT_EN.
module dcm_clkgen_prog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_m,
  input  logic [7:0] cmd_d,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       prog_en,
  output logic       prog_data,
  input  logic       prog_done,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE, LOAD_D, GAP_D, LOAD_M, GAP_M, GO, WAIT_DONE
  } state_t;

  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] m_q, d_q, m_n, d_n;
  logic       prog_en_n, prog_data_n, done_n, error_n;
  logic       timeout;

  // 10-bit load word: start bit 1, select bit (0 = D, 1 = M), then 8 value bits LSB first
  function automatic logic load_bit(input logic sel, input logic [7:0] val, input logic [3:0] cnt);
    logic [3:0] idx;
    idx = cnt - 4'd2;
    if (cnt == 4'd0)      return 1'b1;
    else if (cnt == 4'd1) return sel;
    else                  return val[idx[2:0]];
  endfunction

  always_comb begin
    state_n   = state;
    bit_cnt_n = 4'd0;
    m_n       = m_q;
    d_n       = d_q;
    done_n    = 1'b0;
    error_n   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          m_n = cmd_m;
          d_n = cmd_d;
          if (cmd_m == 8'd0) error_n = 1'b1;
          else               state_n = LOAD_D;
        end
      end
      LOAD_D: begin
        if (bit_cnt == 4'd9) state_n = GAP_D;
        else                 bit_cnt_n = bit_cnt + 4'd1;
      end
      GAP_D: state_n = LOAD_M;
      LOAD_M: begin
        if (bit_cnt == 4'd9) state_n = GAP_M;
        else                 bit_cnt_n = bit_cnt + 4'd1;
      end
      GAP_M: state_n = GO;
      GO:    state_n = WAIT_DONE;
      WAIT_DONE: begin
        if (prog_done) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (timeout) begin
          error_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they can be registered without a cycle of lag
  always_comb begin
    prog_en_n   = 1'b0;
    prog_data_n = 1'b0;
    case (state_n)
      LOAD_D: begin
        prog_en_n   = 1'b1;
        prog_data_n = load_bit(1'b0, d_n, bit_cnt_n);
      end
      LOAD_M: begin
        prog_en_n   = 1'b1;
        prog_data_n = load_bit(1'b1, m_n, bit_cnt_n);
      end
      GO:      prog_en_n = 1'b1;
      default: prog_en_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      m_q       <= 8'd0;
      d_q       <= 8'd0;
      prog_en   <= 1'b0;
      prog_data <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      m_q       <= m_n;
      d_q       <= d_n;
      prog_en   <= prog_en_n;
      prog_data <= prog_data_n;
      cmd_ready <= (state_n == IDLE);
      busy      <= (state_n != IDLE);
      done      <= done_n;
      error     <= error_n;
    end
  end

`ifdef DCM_PROG_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmo_cnt <= '0;
    else if (state == WAIT_DONE && state_n == WAIT_DONE)
      tmo_cnt <= tmo_cnt + 1'b1;
    else
      tmo_cnt <= '0;
  end

  assign timeout = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/dcm_clkgen_prog.md
DCM_CLKGEN_PROG -- requirements
Module: dcm_clkgen_prog

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the maximum number of cycles spent in WAIT_DONE before the error path.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, also driven externally as DCM PROGCLK.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_m, input, 8 bits: desired multiplier minus one (M-1).
REQ-005 SHALL have port cmd_d, input, 8 bits: desired divider minus one (D-1).
REQ-006 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-007 SHALL have port cmd_ready, output, 1 bit: command accepted when high together with cmd_valid.
REQ-008 SHALL have port prog_en, output, 1 bit: DCM PROGEN.
REQ-009 SHALL have port prog_data, output, 1 bit: DCM PROGDATA.
REQ-010 SHALL have port prog_done, input, 1 bit: DCM PROGDONE, synchronous to clk.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse on successful completion.
REQ-013 SHALL have port error, output, 1 bit: one-cycle pulse on a rejected command or a timeout.

Function
REQ-014 SHALL implement states IDLE, LOAD_D, GAP_D, LOAD_M, GAP_M, GO, WAIT_DONE.
REQ-015 SHALL drive cmd_ready = 1 only in IDLE, and SHALL latch cmd_m and cmd_d on the handshake.
REQ-016 SHALL treat cmd_m == 0 (M=1) as an illegal command: stay in IDLE, pulse error the next cycle, issue no PROGEN activity.
REQ-017 SHALL, on a legal handshake at cycle N, drive LOAD_D for cycles N+1..N+10:
  - prog_en = 1 throughout;
  - prog_data = 1, then 0, then D-1 bits 0..7, LSB first.
REQ-018 SHALL hold prog_en = 0 and prog_data = 0 in GAP_D for exactly 1 cycle (N+11).
REQ-019 SHALL drive LOAD_M for cycles N+12..N+21:
  - prog_en = 1 throughout;
  - prog_data = 1, then 1, then M-1 bits 0..7, LSB first.
REQ-020 SHALL hold GAP_M for 1 cycle (N+22) with prog_en = 0.
REQ-021 SHALL drive GO for 1 cycle (N+23) with prog_en = 1 and prog_data = 0, then enter WAIT_DONE with prog_en = 0.
REQ-022 SHALL, in WAIT_DONE, pulse done and return to IDLE on the cycle after the first cycle prog_done = 1.
REQ-023 SHALL ignore prog_done in all states except WAIT_DONE.
REQ-024 SHALL ignore cmd_valid while busy; a held cmd_valid SHALL be accepted in the first IDLE cycle after completion.
REQ-025 SHALL sequence the 10-bit loads with a 4-bit bit counter that clears on each state entry and never wraps past 9.
REQ-026 SHALL register all outputs, with no combinational path from any input to prog_en or prog_data.

Reset
REQ-027 SHALL, while rst = 1, force the following asynchronously:
  - state = IDLE;
  - prog_en = 0, prog_data = 0;
  - busy = 0, done = 0, error = 0;
  - cmd_ready = 0, and bit and timeout counters = 0.
REQ-028 SHALL raise cmd_ready the first cycle after rst deasserts.
REQ-029 SHALL, on rst mid-sequence, abandon the sequence with prog_en low within the reset assertion and emit no done or error pulse.

Configuration
REQ-030 SHALL, with macro DCM_PROG_TIMEOUT_EN defined:
  - count cycles in WAIT_DONE;
  - on reaching TIMEOUT_CYCLES without prog_done, pulse error, skip done, and return to IDLE.
REQ-031 SHALL, without DCM_PROG_TIMEOUT_EN:
  - wait in WAIT_DONE indefinitely;
  - never generate a timeout error;
  - omit the timeout counter from the netlist.

Verification
REQ-032 SHALL cover a legal command: cmd_m=24, cmd_d=0.
  - prog_data bitstream across N+1..N+23 = 1,0,00000000,gap,1,1,00011000 (LSB first),gap,GO 0.
  - prog_done=1 at N+30 -> done=1 at N+31, cmd_ready=1 at N+31.
REQ-033 SHALL cover an illegal command: cmd_m=0, cmd_d=3 -> error pulse at N+1, prog_en stays 0, busy stays 0.
REQ-034 SHALL cover a timeout: with DCM_PROG_TIMEOUT_EN, TIMEOUT_CYCLES=16, prog_done held 0 -> error at WAIT_DONE entry +16, done never asserted, return to IDLE.
REQ-035 SHALL cover back-to-back commands: cmd_valid held high with two command values -> second accepted only after done, with no overlap of prog_en windows.
REQ-036 SHALL cover reset mid-sequence: rst asserted at N+15 (inside LOAD_M) -> prog_en=0 immediately, no done or error pulse, cmd_ready=1 one cycle after release.
REQ-037 SHALL cover a spurious prog_done: prog_done=1 during LOAD_D -> ignored, sequence completes normally on the real prog_done.
